mips_seq_ctrl: RTL

MIPS_SEQ_CTRL -- requirements
Module: mips_seq_ctrl

---
 rtl/mips_seq_ctrl_if.sv | 39 +++
 rtl/mips_seq_ctrl.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/mips_seq_ctrl_if.sv
// Bundle of signals between the multi-cycle MIPS sequencer and its datapath.
//   master : the sequencer. It samples opcode/imemReady/dmemReady/halt and
//            drives the datapath strobes, the ALU class, the state code,
//            the illegal-opcode pulse and the retired-instruction count.
//   slave  : the datapath/memory side, with every direction reversed.
// DATA_W sets the width of the instret counter.
interface mips_seq_ctrl_if #(
  parameter int DATA_W = 32
) ();
  logic [5:0]        opcode;
  logic              imemReady;
  logic              dmemReady;
  logic              halt;
  logic              pcWrite;
  logic              irWrite;
  logic              regWrite;
  logic              memRead;
  logic              memWrite;
  logic              branch;
  logic              regDst;
  logic              memToReg;
  logic              aluSrc;
  logic [1:0]        aluOp;
  logic [2:0]        state;
  logic              illegalInstr;
  logic [DATA_W-1:0] instret;

  modport master (
    input  opcode, imemReady, dmemReady, halt,
    output pcWrite, irWrite, regWrite, memRead, memWrite, branch,
           regDst, memToReg, aluSrc, aluOp, state, illegalInstr, instret
  );

  modport slave (
    output opcode, imemReady, dmemReady, halt,
    input  pcWrite, irWrite, regWrite, memRead, memWrite, branch,
           regDst, memToReg, aluSrc, aluOp, state, illegalInstr, instret
  );
endinterface

// File: rtl/mips_seq_ctrl.sv
// Multi-cycle MIPS control sequencer (FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK/HALTED).
// Ports:
//   clk - sole clock, rising edge
//   rst - synchronous active-high reset; aborts any in-flight instruction
//   bus - mips_seq_ctrl_if.master: opcode, imemReady, dmemReady, halt in;
//         datapath strobes, aluOp, state, illegalInstr, instret out
// Supported opcodes: R-type 0x00, lw 0x23, sw 0x2B, beq 0x04, addi 0x08.
module mips_seq_ctrl #(
  parameter int DATA_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  mips_seq_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEMORY    = 3'd3,
    WRITEBACK = 3'd4,
    HALTED    = 3'd5
  } state_t;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;

  state_t            state_q, state_d;
  logic [5:0]        op_q;
  logic [DATA_W-1:0] instret_q;
  logic              retire;

  logic pc_wr, ir_wr, reg_wr, mem_rd, mem_wr, br, reg_dst, mem_to_reg, alu_src, illegal;
  logic [1:0] alu_op;

  function automatic logic is_legal(input logic [5:0] op);
    return (op == OP_R) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_ADDI);
  endfunction

  // The opcode is captured only while in DECODE so later states act on the
  // instruction that was decoded, whatever the IR bus shows afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FETCH;
      op_q      <= 6'h00;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == DECODE) op_q <= bus.opcode;
      if (retire) instret_q <= instret_q + DATA_W'(1);
    end
  end

  always_comb begin
    state_d    = FETCH;   // also the exit for the unused codes 6 and 7
    retire     = 1'b0;
    pc_wr      = 1'b0;
    ir_wr      = 1'b0;
    reg_wr     = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    br         = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src    = 1'b0;
    alu_op     = 2'b00;
    illegal    = 1'b0;
    // Strobes are silenced during reset so an aborted instruction can never
    // commit a register or memory write in the reset cycle.
    if (!rst) begin
      case (state_q)
        FETCH: begin
          if (bus.halt) begin
            state_d = HALTED;
          end else if (bus.imemReady) begin
            ir_wr   = 1'b1;
            pc_wr   = 1'b1;
            state_d = DECODE;
          end else begin
            state_d = FETCH;
          end
        end
        DECODE: begin
          if (is_legal(bus.opcode)) state_d = EXECUTE;
          else                      illegal = 1'b1;
        end
        EXECUTE: begin
          case (op_q)
            OP_R: begin
              alu_op  = 2'b10;
              state_d = WRITEBACK;
            end
            OP_ADDI: begin
              alu_src = 1'b1;
              state_d = WRITEBACK;
            end
            OP_LW, OP_SW: begin
              alu_src = 1'b1;
              state_d = MEMORY;
            end
            OP_BEQ: begin
              alu_op  = 2'b01;
              br      = 1'b1;
              retire  = 1'b1;
            end
            default: state_d = FETCH;
          endcase
        end
        MEMORY: begin
          alu_src = 1'b1;
          if (op_q == OP_LW) begin
            mem_rd  = 1'b1;
            state_d = bus.dmemReady ? WRITEBACK : MEMORY;
          end else if (op_q == OP_SW) begin
            mem_wr  = 1'b1;
            retire  = bus.dmemReady;
            state_d = bus.dmemReady ? FETCH : MEMORY;
          end
        end
        WRITEBACK: begin
          reg_wr     = 1'b1;
          reg_dst    = (op_q == OP_R);
          mem_to_reg = (op_q == OP_LW);
          retire     = 1'b1;
        end
        HALTED: state_d = bus.halt ? HALTED : FETCH;
        default: state_d = FETCH;
      endcase
    end
  end

  assign bus.pcWrite      = pc_wr;
  assign bus.irWrite      = ir_wr;
  assign bus.regWrite     = reg_wr;
  assign bus.memRead      = mem_rd;
  assign bus.memWrite     = mem_wr;
  assign bus.branch       = br;
  assign bus.regDst       = reg_dst;
  assign bus.memToReg     = mem_to_reg;
  assign bus.aluSrc       = alu_src;
  assign bus.aluOp        = alu_op;
  assign bus.state        = state_q;
  assign bus.illegalInstr = illegal;
  assign bus.instret      = instret_q;

endmodule
